// File: rtl/vlg_design_pkg.sv
// Shared defaults and the binary-to-reflected-Gray helper for the vlg_design pipeline.
package vlg_design_pkg;

    localparam int DATA_W_DEF      = 4;
    localparam int DATA_W_MAX      = 16;
    localparam int PIPE_STAGES_DEF = 1;
    localparam int PIPE_STAGES_MAX = 4;

    // Operates at the widest legal width; callers zero-extend and truncate back.
    function automatic logic [DATA_W_MAX-1:0] bin_to_gray(input logic [DATA_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/vlg_design_bin2gray.sv
// Purely combinational binary to reflected-binary Gray converter.
module bin2gray
    import vlg_design_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_bin,
    output logic [DATA_W-1:0] o_gray
);

    // Zero-extension keeps the MSB's neighbour at 0, so the MSB passes through unchanged.
    always_comb begin
        o_gray = DATA_W'(bin_to_gray(DATA_W_MAX'(i_bin)));
    end

endmodule

// File: rtl/vlg_design.sv
// Gray-code converter followed by a PIPE_STAGES-deep register pipeline with synchronous reset.
module vlg_design
    import vlg_design_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int PIPE_STAGES = PIPE_STAGES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_gray
);

    logic [DATA_W-1:0] gray_w;

    bin2gray #(
        .DATA_W (DATA_W)
    ) u_bin2gray (
        .i_bin  (i_data),
        .o_gray (gray_w)
    );

    // Conversion happens once in front of stage 0; later stages are plain delay.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic [DATA_W-1:0] stage_d;
        logic [DATA_W-1:0] stage_q;

        if (s == 0) begin : g_head
            always_comb stage_d = gray_w;
        end else begin : g_tail
            always_comb stage_d = g_stage[s-1].stage_q;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign o_gray = g_stage[PIPE_STAGES-1].stage_q;

endmodule

// File: tb/tb_vlg_design.sv
// Self-checking bench: several vlg_design configurations against a history-based Gray model.
module tb_vlg_design;

    logic       clk;
    logic       rst;
    logic [3:0] d4;
    logic [7:0] d8;
    logic [3:0] o4_p1, o4_p3;
    logic [7:0] o8_p1, o8_p2, o8_p3, o8_p4;

    int n_checks = 0;
    int n_fail   = 0;

    bit         hist_r[$];
    logic [3:0] hist4[$];
    logic [7:0] hist8[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vlg_design #(.DATA_W(4), .PIPE_STAGES(1)) dut_w4_p1 (.i_clk(clk), .i_rst(rst), .i_data(d4), .o_gray(o4_p1));
    vlg_design #(.DATA_W(4), .PIPE_STAGES(3)) dut_w4_p3 (.i_clk(clk), .i_rst(rst), .i_data(d4), .o_gray(o4_p3));
    vlg_design #(.DATA_W(8), .PIPE_STAGES(1)) dut_w8_p1 (.i_clk(clk), .i_rst(rst), .i_data(d8), .o_gray(o8_p1));
    vlg_design #(.DATA_W(8), .PIPE_STAGES(2)) dut_w8_p2 (.i_clk(clk), .i_rst(rst), .i_data(d8), .o_gray(o8_p2));
    vlg_design #(.DATA_W(8), .PIPE_STAGES(3)) dut_w8_p3 (.i_clk(clk), .i_rst(rst), .i_data(d8), .o_gray(o8_p3));
    vlg_design #(.DATA_W(8), .PIPE_STAGES(4)) dut_w8_p4 (.i_clk(clk), .i_rst(rst), .i_data(d8), .o_gray(o8_p4));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray_of(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Output after the latest edge: zero if any of the last p edges saw reset,
    // otherwise the Gray of the value sampled p-1 edges before the latest one.
    function automatic logic [7:0] model(input int p, input bit wide);
        int n;
        n = hist_r.size();
        for (int k = 0; k < p; k++) begin
            if (hist_r[n-1-k]) return 8'h00;
        end
        if (wide) return gray_of(hist8[n-p]);
        return gray_of({4'h0, hist4[n-p]}) & 8'h0f;
    endfunction

    task automatic check_all();
        check("w4_p1", {12'h0, o4_p1}, {8'h0, model(1, 1'b0)});
        check("w4_p3", {12'h0, o4_p3}, {8'h0, model(3, 1'b0)});
        check("w8_p1", {8'h0, o8_p1}, {8'h0, model(1, 1'b1)});
        check("w8_p2", {8'h0, o8_p2}, {8'h0, model(2, 1'b1)});
        check("w8_p3", {8'h0, o8_p3}, {8'h0, model(3, 1'b1)});
        check("w8_p4", {8'h0, o8_p4}, {8'h0, model(4, 1'b1)});
    endtask

    // Drive at the falling edge, let one rising edge sample, then check at the next falling edge.
    task automatic cycle(input bit r, input logic [3:0] a4, input logic [7:0] a8);
        rst = r;
        d4  = a4;
        d8  = a8;
        @(posedge clk);
        hist_r.push_back(r);
        hist4.push_back(a4);
        hist8.push_back(a8);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [3:0] sweep_exp[16];
        logic [3:0] prev;
        logic [3:0] v;

        sweep_exp = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                      4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        rst = 1'b1;
        d4  = '0;
        d8  = '0;
        @(negedge clk);

        // Reset held with random data: every output must stay zero.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            check("rst_w8_p1", {8'h0, o8_p1}, 16'h0);
            check("rst_w4_p3", {12'h0, o4_p3}, 16'h0);
        end
        cycle(1'b0, 4'h0, 8'h00);
        check("rel_w4_p1", {12'h0, o4_p1}, 16'h0);

        // Sweep 1..15,0 on the 4-bit, 1-stage unit.
        for (int i = 1; i <= 16; i++) begin
            v = 4'(i);
            cycle(1'b0, v, 8'(i));
            check("sweep", {12'h0, o4_p1}, {12'h0, sweep_exp[i-1]});
        end

        // Increment through a full wrap twice: consecutive outputs differ in one bit.
        prev = o4_p1;
        for (int i = 1; i <= 33; i++) begin
            v = 4'(i);
            cycle(1'b0, v, 8'(i));
            check("hamming", 16'($countones(o4_p1 ^ prev)), 16'd1);
            prev = o4_p1;
        end

        // Latency on the 3-stage unit: step 0 -> 5.
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 8'h00);
        cycle(1'b0, 4'h5, 8'h05);
        check("lat_e1", {12'h0, o4_p3}, 16'h0);
        cycle(1'b0, 4'h5, 8'h05);
        check("lat_e2", {12'h0, o4_p3}, 16'h0);
        cycle(1'b0, 4'h5, 8'h05);
        check("lat_e3", {12'h0, o4_p3}, 16'h7);

        // Mid-stream reset pulse while i_data = 9.
        for (int i = 1; i <= 8; i++) cycle(1'b0, 4'(i), 8'(i));
        cycle(1'b1, 4'h9, 8'h09);
        check("mid_rst", {12'h0, o4_p1}, 16'h0);
        check("mid_rst_p3", {12'h0, o4_p3}, 16'h0);
        cycle(1'b0, 4'hA, 8'h0A);
        check("mid_resume", {12'h0, o4_p1}, 16'hF);
        cycle(1'b0, 4'hB, 8'h0B);
        check("mid_p3_flush", {12'h0, o4_p3}, 16'h0);

        // Random regression with rare reset pulses.
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 299) == 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vlg_design.md
VLG_DESIGN -- requirements
Module: vlg_design

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-002 The block SHALL have parameter DATA_W, default 4: width of the binary input and the Gray output, legal range 2..16.
REQ-003 The block SHALL have parameter PIPE_STAGES, default 1: number of register stages from i_data to o_gray, legal range 1..4.
REQ-004 Port i_clk SHALL be an input, 1 bit wide: the clock; all state updates occur on its rising edge.
REQ-005 Port i_rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-006 Port i_data SHALL be an input, DATA_W bits wide: unsigned binary value, sampled on every rising edge of i_clk.
REQ-007 Port o_gray SHALL be an output, DATA_W bits wide: registered reflected-binary Gray code of i_data.

Function
REQ-008 Conversion SHALL be gray[DATA_W-1] = bin[DATA_W-1] and gray[k] = bin[k+1] XOR bin[k] for k < DATA_W-1, i.e. bin XOR (bin >> 1), with no carries and no width growth.
REQ-009 o_gray SHALL equal the Gray code of the i_data value sampled PIPE_STAGES rising edges earlier; with PIPE_STAGES=1 it updates on the edge after i_data is sampled.
REQ-010 Conversion SHALL be applied exactly once, before the first register stage; the later stages only delay the value.
REQ-011 o_gray SHALL be driven directly from a flop, with no combinational path from i_data to o_gray.
REQ-012 A new input SHALL be accepted every cycle, with no handshake and no stall; throughput is one conversion per clock.
REQ-013 Input wrap-around (all-ones to zero) SHALL need no special handling; the Gray of all-ones is a 1 in the MSB only, followed by 0.
REQ-014 Consecutive binary inputs differing by +1 SHALL produce o_gray values differing in exactly one bit, including at the wrap.
REQ-015 With i_data held constant, o_gray SHALL stay constant after PIPE_STAGES cycles.

Reset
REQ-016 While i_rst is sampled high on a rising edge of i_clk, all pipeline registers, and so o_gray, SHALL load 0.
REQ-017 Reset SHALL take priority over data capture in the same cycle.
REQ-018 A reset asserted mid-stream SHALL flush every in-flight value, so none appears on o_gray after reset.
REQ-019 After i_rst deasserts, the first valid o_gray SHALL appear PIPE_STAGES edges after the first sampled i_data.
REQ-020 Reset SHALL have no asynchronous path, and before the first reset edge o_gray is undefined.

Structure
REQ-021 A shared package SHALL hold the DATA_W default, the PIPE_STAGES default and its maximum of 4, and a pure bin-to-Gray function of DATA_W bits.
REQ-022 The combinational converter SHALL be one sub-module, bin2gray, parameterised by DATA_W; vlg_design instantiates it and owns the pipeline registers.
REQ-023 The pipeline SHALL be built as a generate loop over PIPE_STAGES, with no per-stage hand-coding.
REQ-024 The RTL SHALL contain no latches, no multi-driven nets and no initial blocks in synthesizable code.

Verification
REQ-025 Reset check: i_rst high for 100 cycles with random i_data -> o_gray = 0 throughout and one cycle after release.
REQ-026 Sweep (DATA_W=4, PIPE_STAGES=1): i_data = 1,2,...,15,0, one value per cycle -> o_gray one cycle later = 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
REQ-027 Single-bit property: increment i_data each cycle through 0..15 and wrap -> every consecutive o_gray pair has Hamming distance 1.
REQ-028 Latency (PIPE_STAGES=3): step i_data 0->5 -> o_gray is 0 for 2 further edges, then 7 on the third edge after sampling.
REQ-029 Mid-stream reset: during the sweep, pulse i_rst high for one edge when i_data=9 -> o_gray=0 on that edge, then resumes with Gray(i_data) one cycle later.
REQ-030 Random regression: DATA_W=8, 10,000 random inputs -> o_gray matches a bin XOR (bin>>1) model delayed by PIPE_STAGES, for PIPE_STAGES = 1..4.
